fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage upstream of decode/control/regfile/ALU in the 16-bit CPU.
//  Owns the PC and drives the combinational instruction memory address.
//  Buffers {pc, instr} pairs in a 2-entry queue and hands them to decode over a valid/ready handshake.
//  Accepts a redirect (jump/branch target) that flushes in-flight fetches.
// PARAMETERS
//  PC_W      16       PC and imem address width
//  INSTR_W   16       instruction width
//  RESET_PC  16'h0000 PC value loaded on reset
//  QDEPTH    2        fetch queue entries (only 2 is supported)
// PORTS
//  clk            in   1        rising-edge clock
//  rst            in   1        asynchronous, active-high reset
//  fetch_en       in   1        1 = fetching allowed (RUN), 0 = hold (IDLE)
//  imem_addr      out  PC_W     address to imem (== current PC)
//  imem_data      in   INSTR_W  instruction at imem_addr, same cycle (combinational imem)
//  redirect_valid in   1        take redirect this cycle
//  redirect_pc    in   PC_W     redirect target
//  dec_valid      out  1        queue head is valid
//  dec_ready      in   1        decode accepts the head this cycle
//  dec_instr      out  INSTR_W  head instruction
//  dec_pc         out  PC_W     PC of the head instruction
// BEHAVIOUR
//  Reset (async, while rst=1): pc=RESET_PC, queue count=0, state=IDLE, dec_valid=0,
//   dec_instr=0, dec_pc=0, imem_addr=RESET_PC.
//  FSM: IDLE -> RUN when fetch_en=1; RUN -> IDLE when fetch_en=0. No redirect is needed for either transition.
//   IDLE: no enqueue, pc holds. Queued entries still drain to decode.
//  deq = dec_valid & dec_ready. Pops the head at the clock edge.
//  enq = (state==RUN) & fetch_en & ~redirect_valid & (count<2 | deq).
//   An enqueue captures {imem_addr, imem_data} into the tail; pc <= pc+1.
//  PC arithmetic is modulo 2^PC_W: 16'hFFFF+1 = 16'h0000, with no flag.
//  Full queue with deq and enq in the same cycle: both happen, count stays 2.
//  Empty queue: deq is impossible (dec_valid=0), and enq makes count 1.
//  Latency: an enqueue at edge N gives dec_valid=1 with that instruction after edge N (1 cycle).
//  Redirect has the highest priority. At the edge: queue cleared (count=0), pc <= redirect_pc, no enqueue.
//   Any deq in that cycle is still reported as accepted by decode.
//   Next cycle: dec_valid=0, imem_addr=redirect_pc.
//   The target instruction is valid to decode one edge later.
//  Redirect while IDLE: pc is loaded and the queue is flushed. Fetch resumes from the target on the next RUN.
//  Outputs dec_instr/dec_pc are the queue head (registered). When count=0 they hold their last value.
//  Reset mid-operation: every state is cleared immediately. Handshakes in progress are discarded.
// CONFIGURATION
//  FETCH_PERF_EN defined: adds outputs
//   perf_fetch_cnt [31:0]: +1 per enq
//   perf_stall_cnt [31:0]: +1 per cycle with dec_valid & ~dec_ready
//   Both are reset to 0 and saturate at 32'hFFFF_FFFF.
//  FETCH_PERF_EN undefined: those ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  cpu_defs.vh (shared include):
//   PC_W, INSTR_W, RESET_PC defaults
//   FSM state encodings FETCH_IDLE=1'b0, FETCH_RUN=1'b1
//   queue entry width (PC_W+INSTR_W)
//  Sub-module fetch_queue:
//   2-entry FIFO with head/tail pointers, 2-bit count, flush input, simultaneous push/pop.
//  fetch_unit top holds the FSM, PC register, enq/deq logic, redirect handling and optional perf counters.
// TESTING
//  1 Reset, fetch_en=1, dec_ready=1, imem[i]=16'h1000+i
//    -> dec_pc 0,1,2,3 on consecutive cycles, dec_instr=16'h1000..16'h1003, first valid 1 cycle after the first edge.
//  2 dec_ready=0 for 5 cycles
//    -> count stops at 2, pc stops at 2, imem_addr stable.
//    Then dec_ready=1 -> PCs 0,1,2,... arrive in order, none lost or duplicated.
//  3 Redirect to 16'h0040 while the queue is full
//    -> next cycle dec_valid=0, the cycle after: dec_pc=16'h0040.
//    Old entries never appear.
//  4 Reset PC to 16'hFFFE, free-run -> dec_pc FFFE, FFFF, 0000, 0001.
//  5 fetch_en=0 with 2 queued entries
//    -> both drain, then dec_valid=0 and pc holds.
//    Raise fetch_en -> fetching resumes at the held pc.
//  6 Assert rst mid-stream (async, between edges)
//    -> dec_valid=0 and imem_addr=RESET_PC immediately.
//    FETCH_PERF_EN build: both counters=0, and stall_cnt counts exactly the 5 stall cycles of test 2.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: default widths, reset PC,
// FSM state encodings, queue entry width and a saturating counter helper.
package fetch_unit_pkg;

    localparam int          PC_W_DEF     = 16;
    localparam int          INSTR_W_DEF  = 16;
    localparam logic [15:0] RESET_PC_DEF = 16'h0000;

    // One queue entry carries {pc, instr}
    localparam int ENTRY_W_DEF = PC_W_DEF + INSTR_W_DEF;

    typedef enum logic {
        FETCH_IDLE = 1'b0,
        FETCH_RUN  = 1'b1
    } fetch_state_e;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetched {pc, instr} entries.
// Supports simultaneous push and pop and a flush that empties it.
// The head is kept in its own register so the output holds its last
// value once the queue drains.
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int DATA_W = ENTRY_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [1:0]        count_o,
    output logic [DATA_W-1:0] head_o
);

    logic [DATA_W-1:0] mem_q [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q,  count_d;
    logic [DATA_W-1:0] head_q,   head_d;

    // Next pointers, occupancy and head-of-queue value
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (flush_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push_i) wr_ptr_d = ~wr_ptr_q;
            if (pop_i)  rd_ptr_d = ~rd_ptr_q;
            count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
            if (pop_i) begin
                // Second entry moves up, or the incoming entry becomes head
                if (count_q == 2'd2)
                    head_d = mem_q[~rd_ptr_q];
                else if (push_i)
                    head_d = push_data_i;
            end else if (count_q == 2'd0 && push_i) begin
                head_d = push_data_i;
            end
        end
    end

    // Storage, pointers and head register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            head_q   <= '0;
        end else begin
            if (push_i && !flush_i)
                mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = head_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the combinational imem
// address, buffers fetched {pc, instr} pairs for decode and handles
// redirects (flush + PC load).
// Optional build macro FETCH_PERF_EN adds saturating fetch/stall counters.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter int              INSTR_W  = INSTR_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF[PC_W-1:0],
    parameter int              QDEPTH   = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               fetch_en_i,
    output logic [PC_W-1:0]    imem_addr_o,
    input  logic [INSTR_W-1:0] imem_data_i,
    input  logic               redirect_valid_i,
    input  logic [PC_W-1:0]    redirect_pc_i,
    output logic               dec_valid_o,
    input  logic               dec_ready_i,
    output logic [INSTR_W-1:0] dec_instr_o,
    output logic [PC_W-1:0]    dec_pc_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetch_cnt_o,
    output logic [31:0]        perf_stall_cnt_o
`endif
);

    localparam int ENTRY_W = PC_W + INSTR_W;

    fetch_state_e        state_q;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [1:0]          count;
    logic [ENTRY_W-1:0]  head;
    logic                enq, deq, q_has_room;

    // The queue is built for exactly two entries
    if (QDEPTH != 2) begin : g_bad_depth
        initial $error("fetch_unit: only QDEPTH=2 is supported");
    end

    assign q_has_room = (count < 2'd2) || deq;
    assign deq = dec_valid_o && dec_ready_i;
    assign enq = (state_q == FETCH_RUN) && fetch_en_i && !redirect_valid_i && q_has_room;

    // Redirect beats sequential advance
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid_i)
            pc_d = redirect_pc_i;
        else if (enq)
            pc_d = pc_q + 1'b1;
    end

    // Run/idle FSM and PC register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= FETCH_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            pc_q <= pc_d;
            case (state_q)
                FETCH_IDLE: if (fetch_en_i)  state_q <= FETCH_RUN;
                FETCH_RUN:  if (!fetch_en_i) state_q <= FETCH_IDLE;
                default:                     state_q <= FETCH_IDLE;
            endcase
        end
    end

    fetch_queue #(
        .DATA_W (ENTRY_W)
    ) u_queue (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (redirect_valid_i),
        .push_i      (enq),
        .push_data_i ({pc_q, imem_data_i}),
        .pop_i       (deq),
        .count_o     (count),
        .head_o      (head)
    );

    assign imem_addr_o = pc_q;
    assign dec_valid_o = (count != 2'd0);
    assign dec_pc_o    = head[ENTRY_W-1:INSTR_W];
    assign dec_instr_o = head[INSTR_W-1:0];

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;

    // Saturating counts of enqueues and decode back-pressure cycles
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            if (enq)
                fetch_cnt_q <= sat_inc32(fetch_cnt_q);
            if (dec_valid_o && !dec_ready_i)
                stall_cnt_q <= sat_inc32(stall_cnt_q);
        end
    end

    assign perf_fetch_cnt_o = fetch_cnt_q;
    assign perf_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order scoreboard of expected PCs.
// imem is modelled as instr = 16'h1000 + addr.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [15:0] dec_instr;
    logic [15:0] dec_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [15:0] sb [$];

    always #5 clk = ~clk;

    assign imem_data = 16'h1000 + imem_addr;

    fetch_unit dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .fetch_en_i       (fetch_en),
        .imem_addr_o      (imem_addr),
        .imem_data_i      (imem_data),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .dec_valid_o      (dec_valid),
        .dec_ready_i      (dec_ready),
        .dec_instr_o      (dec_instr),
        .dec_pc_o         (dec_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt_o (perf_fetch_cnt),
        .perf_stall_cnt_o (perf_stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Score the handshake that the coming edge will take, then advance one cycle
    task automatic tick();
        logic [15:0] e;
        if (dec_valid === 1'b1 && dec_ready === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            chk("hs_pc", {16'h0, dec_pc}, {16'h0, e});
            chk("hs_instr", {16'h0, dec_instr}, {16'h0, 16'h1000 + e});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_seq(input logic [15:0] start, input int n);
        for (int i = 0; i < n; i++) sb.push_back(start + 16'(i));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_valid", {31'h0, dec_valid}, 32'd0);
        chk("rst_addr",  {16'h0, imem_addr}, 32'h0000);
        chk("rst_pc",    {16'h0, dec_pc}, 32'd0);
        chk("rst_instr", {16'h0, dec_instr}, 32'd0);
        sb.delete();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 16'h0; dec_ready = 1'b0;

        // 1: free-running fetch from reset
        do_reset();
        fetch_en = 1'b1; dec_ready = 1'b1;
        push_seq(16'h0000, 4);
        tick();
        chk("t1_first_edge_valid", {31'h0, dec_valid}, 32'd0);
        tick();
        chk("t1_valid", {31'h0, dec_valid}, 32'd1);
        chk("t1_pc0",   {16'h0, dec_pc}, 32'h0000);
        chk("t1_ins0",  {16'h0, dec_instr}, 32'h1000);
        repeat (4) tick();
        chk("t1_sb_empty", sb.size(), 32'd0);

        // 2: back-pressure fills the queue, then drains in order
        do_reset();
        fetch_en = 1'b1; dec_ready = 1'b0;
        repeat (7) tick();
        chk("t2_addr_hold", {16'h0, imem_addr}, 32'h0002);
        chk("t2_valid",     {31'h0, dec_valid}, 32'd1);
        chk("t2_head",      {16'h0, dec_pc}, 32'h0000);
`ifdef FETCH_PERF_EN
        chk("t2_perf_stall", perf_stall_cnt, 32'd5);
        chk("t2_perf_fetch", perf_fetch_cnt, 32'd2);
`endif
        dec_ready = 1'b1;
        push_seq(16'h0000, 8);
        repeat (8) tick();
        chk("t2_sb_empty", sb.size(), 32'd0);

        // 3: redirect with a full queue
        dec_ready = 1'b0;
        repeat (2) tick();
        chk("t3_full_valid", {31'h0, dec_valid}, 32'd1);
        sb.delete();
        redirect_valid = 1'b1; redirect_pc = 16'h0040;
        tick();
        redirect_valid = 1'b0;
        chk("t3_flush_valid", {31'h0, dec_valid}, 32'd0);
        chk("t3_flush_addr",  {16'h0, imem_addr}, 32'h0040);
        tick();
        chk("t3_tgt_valid", {31'h0, dec_valid}, 32'd1);
        chk("t3_tgt_pc",    {16'h0, dec_pc}, 32'h0040);
        chk("t3_tgt_instr", {16'h0, dec_instr}, 32'h1040);
        push_seq(16'h0040, 4);
        dec_ready = 1'b1;
        repeat (4) tick();
        chk("t3_sb_empty", sb.size(), 32'd0);

        // 4: PC wraps modulo 2^16
        sb.delete();
        redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
        tick();
        redirect_valid = 1'b0;
        push_seq(16'hFFFE, 4);
        repeat (5) tick();
        chk("t4_sb_empty", sb.size(), 32'd0);
        chk("t4_addr",     {16'h0, imem_addr}, 32'h0003);

        // 5: fetch_en low drains the queue and holds the PC
        sb.delete();
        dec_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 16'h0100;
        tick();
        redirect_valid = 1'b0;
        repeat (2) tick();
        chk("t5_full_addr", {16'h0, imem_addr}, 32'h0102);
        fetch_en = 1'b0; dec_ready = 1'b1;
        push_seq(16'h0100, 2);
        repeat (2) tick();
        chk("t5_drained",  {31'h0, dec_valid}, 32'd0);
        chk("t5_sb_empty", sb.size(), 32'd0);
        chk("t5_hold_pc",  {16'h0, dec_pc}, 32'h0101);
        repeat (2) tick();
        chk("t5_idle_valid", {31'h0, dec_valid}, 32'd0);
        chk("t5_idle_addr",  {16'h0, imem_addr}, 32'h0102);
        fetch_en = 1'b1;
        push_seq(16'h0102, 3);
        repeat (5) tick();
        chk("t5_resume_sb", sb.size(), 32'd0);

        // 6: asynchronous reset between edges
        repeat (2) tick();
        #2 rst = 1'b1;
        #1;
        chk("t6_valid", {31'h0, dec_valid}, 32'd0);
        chk("t6_addr",  {16'h0, imem_addr}, 32'h0000);
        chk("t6_pc",    {16'h0, dec_pc}, 32'h0000);
`ifdef FETCH_PERF_EN
        chk("t6_perf_fetch", perf_fetch_cnt, 32'd0);
        chk("t6_perf_stall", perf_stall_cnt, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
